day_night_detector: RTL and testbench
=====================================

// Module: day_night_detector
// PURPOSE
//  Upstream stage of the traffic timer. Produces its day input.
//  Takes ambient-light ADC samples over a valid/ready handshake.
//  Averages every 4 accepted samples and classifies each average with hysteresis.
//  The day/night decision changes only after a persistence count, so the timer
//  never flips between cycle mode and yellow-blink mode on transient light.
// PARAMETERS
//  SAMPLE_W      8    ADC sample width
//  DAY_THRESH    160  average >= this qualifies as "bright"
//  NIGHT_THRESH  96   average < this qualifies as "dark"; must be < DAY_THRESH
//  HOLD_COUNT    16   consecutive qualifying averages needed to switch; >= 1
//  CNT_W         5    persistence counter width; must hold HOLD_COUNT
// PORTS
//  clk           in   1         clock, rising edge
//  reset         in   1         asynchronous, active-high
//  sample_valid  in   1         sample present
//  sample        in   SAMPLE_W  ambient light level, unsigned
//  sample_ready  out  1         block can accept a sample
//  day           out  1         registered decision: 1 = day, 0 = night
//  day_change    out  1         one-cycle pulse on every change of day
//  avg_level     out  SAMPLE_W  most recent completed 4-sample average
// BEHAVIOUR
//  Reset values: day=0, day_change=0, avg_level=0, sample_ready=0, state=INIT.
//    The window counter, accumulator and persistence counter are cleared.
//  sample_ready goes to 1 on the first clk edge after reset deasserts.
//    It then stays 1; the block never stalls.
//  A sample is accepted on an edge where sample_valid & sample_ready = 1.
//    Cycles with sample_valid low are ignored and do not advance the window.
//  Accumulator is SAMPLE_W+2 bits wide, so a sum of 4 samples never overflows.
//    avg = sum[SAMPLE_W+1:2] (truncating divide by 4).
//  4th accepted sample: on that edge avg_level updates, the state is evaluated
//    and the window restarts (count 0, accumulator 0).
//  Latency: day/day_change are visible the cycle after the 4th sample is accepted.
//  States:
//    INIT:  first average decides immediately. avg >= DAY_THRESH -> DAY,
//           else NIGHT. No persistence applies.
//    DAY:   avg < NIGHT_THRESH increments persist_cnt; any other avg clears it.
//           When this average makes persist_cnt reach HOLD_COUNT -> NIGHT,
//           persist_cnt cleared.
//    NIGHT: mirror of DAY. avg >= DAY_THRESH counts; HOLD_COUNT-th -> DAY.
//  Averages in [NIGHT_THRESH, DAY_THRESH) clear persist_cnt in both states.
//  persist_cnt saturates and cannot wrap.
//  day = (state==DAY); INIT reads as night.
//  day_change pulses exactly when day changes value, including INIT->DAY.
//    INIT->NIGHT gives no pulse.
//  Reset mid-window or mid-persistence discards all partial progress.
// CONFIGURATION
//  FORCE_OVERRIDE_EN defined: adds inputs force_en and force_day (1 bit each).
//    While force_en=1: state = force_day ? DAY : NIGHT on each edge.
//    Window and persist_cnt are held cleared; accepted samples are discarded.
//    day_change pulses if day changes.
//    On release, normal operation resumes from the forced state; INIT is not re-entered.
//  FORCE_OVERRIDE_EN undefined: ports absent, no override logic.
// TESTING (HOLD_COUNT=3)
//  1. Reset, then 4 samples of 200 -> avg_level=200, day=1, one day_change pulse.
//  2. From DAY: averages 50,50,120,50,50,50 -> day stays 1 until the sixth
//     average. 120 clears the count; then day=0 with one pulse.
//  3. Hysteresis: from NIGHT and from DAY, 10 averages of 120 -> day unchanged,
//     no pulse.
//  4. Samples 0,255,255,255 separated by random valid-low gaps -> avg_level=191.
//     Only accepted samples are counted.
//  5. 2 samples accepted, then reset pulse -> day=0, avg_level=0.
//     The next 4 samples of 200 start a fresh window and give day=1 (INIT path).
//  6. (FORCE_OVERRIDE_EN) DAY, force_en=1, force_day=0 -> day=0 next cycle, one pulse.
//     Release, then 3 averages of 200 -> day=1.

Source files
------------

// File: rtl/day_night_detector.sv
// day_night_detector
//   Ambient-light classifier feeding the traffic timer's day input.
//   Samples arrive over a valid/ready handshake (ready is high from the first
//   edge after reset and never drops). Every 4 accepted samples are averaged.
//   Each average is classified with hysteresis (bright / dark / in-between),
//   and the day/night decision only moves after HOLD_COUNT consecutive
//   qualifying averages, so short light transients never flip the timer mode.
//
//   Optional build macro: FORCE_OVERRIDE_EN
//     When defined, adds force_en / force_day inputs that pin the decision
//     to DAY or NIGHT. While forcing, the window and persistence count are
//     held cleared. On release, operation resumes from the forced state.
module day_night_detector #(
  parameter int SAMPLE_W     = 8,
  parameter int DAY_THRESH   = 160,
  parameter int NIGHT_THRESH = 96,
  parameter int HOLD_COUNT   = 16,
  parameter int CNT_W        = 5
) (
  input  logic                clk,
  input  logic                reset,
`ifdef FORCE_OVERRIDE_EN
  input  logic                force_en,
  input  logic                force_day,
`endif
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample,
  output logic                sample_ready,
  output logic                day,
  output logic                day_change,
  output logic [SAMPLE_W-1:0] avg_level
);

  // Threshold constants resized to the widths they are compared against.
  localparam logic [SAMPLE_W-1:0] DAY_LVL   = SAMPLE_W'(DAY_THRESH);
  localparam logic [SAMPLE_W-1:0] NIGHT_LVL = SAMPLE_W'(NIGHT_THRESH);
  localparam logic [CNT_W-1:0]    HOLD_LVL  = CNT_W'(HOLD_COUNT);
  localparam logic [CNT_W-1:0]    CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_DAY   = 2'd1,
    ST_NIGHT = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  ready_q;
  logic [1:0]            win_cnt_q, win_cnt_d;
  logic [SAMPLE_W+1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]      persist_q, persist_d;
  logic [SAMPLE_W-1:0]   avg_q, avg_d;
  logic                  day_change_q, day_change_d;

  logic                  accept;
  logic                  window_done;
  logic [SAMPLE_W+1:0]   sum_w;
  logic [SAMPLE_W-1:0]   avg_w;
  logic                  is_bright;
  logic                  is_dark;
  logic [CNT_W-1:0]      persist_inc;
  logic                  hold_reached;
  logic                  force_active;
  state_t                force_state;

  // Override source: pins the state while active; constant-off otherwise.
`ifdef FORCE_OVERRIDE_EN
  assign force_active = force_en;
  assign force_state  = force_day ? ST_DAY : ST_NIGHT;
`else
  assign force_active = 1'b0;
  assign force_state  = ST_NIGHT;
`endif

  // Handshake and window arithmetic. The accumulator is two bits wider
  // than a sample, so four samples can never overflow it.
  assign accept      = sample_valid & ready_q;
  assign sum_w       = acc_q + {2'b00, sample};
  assign window_done = accept && (win_cnt_q == 2'd3);
  assign avg_w       = sum_w[SAMPLE_W+1:2];

  // Hysteresis classification of the average completing this cycle.
  assign is_bright    = (avg_w >= DAY_LVL);
  assign is_dark      = (avg_w < NIGHT_LVL);
  assign persist_inc  = (&persist_q) ? persist_q : (persist_q + CNT_ONE);
  assign hold_reached = (persist_inc >= HOLD_LVL);

  // Window counter / accumulator / published average next-state.
  always_comb begin
    win_cnt_d = win_cnt_q;
    acc_d     = acc_q;
    avg_d     = avg_q;
    if (force_active) begin
      // Samples taken during an override are discarded.
      win_cnt_d = 2'd0;
      acc_d     = '0;
    end else if (accept) begin
      if (window_done) begin
        win_cnt_d = 2'd0;
        acc_d     = '0;
        avg_d     = avg_w;
      end else begin
        win_cnt_d = win_cnt_q + 2'd1;
        acc_d     = sum_w;
      end
    end
  end

  // Decision FSM: INIT takes the first average at face value, DAY/NIGHT
  // need HOLD_COUNT consecutive opposite-side averages to switch.
  always_comb begin
    state_d   = state_q;
    persist_d = persist_q;
    if (force_active) begin
      state_d   = force_state;
      persist_d = '0;
    end else if (window_done) begin
      case (state_q)
        ST_INIT: begin
          state_d   = is_bright ? ST_DAY : ST_NIGHT;
          persist_d = '0;
        end
        ST_DAY: begin
          if (is_dark) begin
            if (hold_reached) begin
              state_d   = ST_NIGHT;
              persist_d = '0;
            end else begin
              persist_d = persist_inc;
            end
          end else begin
            persist_d = '0;
          end
        end
        ST_NIGHT: begin
          if (is_bright) begin
            if (hold_reached) begin
              state_d   = ST_DAY;
              persist_d = '0;
            end else begin
              persist_d = persist_inc;
            end
          end else begin
            persist_d = '0;
          end
        end
        default: begin
          state_d   = ST_INIT;
          persist_d = '0;
        end
      endcase
    end
  end

  // Change pulse: fires whenever the day decode differs across this edge.
  // INIT and NIGHT both read as night, so INIT->NIGHT gives no pulse.
  always_comb begin
    day_change_d = (state_q == ST_DAY) ^ (state_d == ST_DAY);
  end

  // State registers with asynchronous reset; all partial progress discarded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_INIT;
      ready_q      <= 1'b0;
      win_cnt_q    <= 2'd0;
      acc_q        <= '0;
      persist_q    <= '0;
      avg_q        <= '0;
      day_change_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ready_q      <= 1'b1;
      win_cnt_q    <= win_cnt_d;
      acc_q        <= acc_d;
      persist_q    <= persist_d;
      avg_q        <= avg_d;
      day_change_q <= day_change_d;
    end
  end

  assign sample_ready = ready_q;
  assign day          = (state_q == ST_DAY);
  assign day_change   = day_change_q;
  assign avg_level    = avg_q;

endmodule

// File: tb/tb_day_night_detector.sv
// tb_day_night_detector
//   Scoreboard bench: the driver applies samples, runs a behavioural model of
//   the light classifier and queues the expected (avg, day, pulse) for the
//   cycle each result should appear. An independent monitor checks every
//   cycle: queued events when due, otherwise steady outputs and no pulse.
`timescale 1ns/1ps
module tb_day_night_detector;

  localparam int SW = 8;
  localparam int DT = 160;
  localparam int NT = 96;
  localparam int HC = 3;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          sample_valid = 1'b0;
  logic [SW-1:0] sample = '0;
  logic          sample_ready;
  logic          day;
  logic          day_change;
  logic [SW-1:0] avg_level;
`ifdef FORCE_OVERRIDE_EN
  logic          force_en = 1'b0;
  logic          force_day = 1'b0;
`endif

  day_night_detector #(
    .SAMPLE_W(SW), .DAY_THRESH(DT), .NIGHT_THRESH(NT),
    .HOLD_COUNT(HC), .CNT_W(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
`ifdef FORCE_OVERRIDE_EN
    .force_en(force_en),
    .force_day(force_day),
`endif
    .sample_valid(sample_valid),
    .sample(sample),
    .sample_ready(sample_ready),
    .day(day),
    .day_change(day_change),
    .avg_level(avg_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    logic [SW-1:0] avg;
    logic          dy;
    logic          chg;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   edge_cnt = 0;

  // Reference model state (driver side)
  int   win[$];
  int   m_mode = 0;       // 0 = not yet decided, 1 = day, 2 = night
  int   m_persist = 0;
  int   m_avg = 0;
  bit   model_ready = 1'b0;
  bit   m_force = 1'b0;
  bit   m_fday = 1'b0;

  task automatic check(string name, logic [10:0] got, logic [10:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s @edge %0d: got avg=%0d day=%0b chg=%0b rdy=%0b, expected avg=%0d day=%0b chg=%0b rdy=%0b",
               name, edge_cnt, got[10:3], got[2], got[1], got[0],
               want[10:3], want[2], want[1], want[0]);
    end
  endtask

  // Monitor: samples 3 ns after each rising edge.
  logic [SW-1:0] cur_avg = '0;
  logic          cur_day = 1'b0;
  exp_t          e;
  always begin
    @(posedge clk);
    edge_cnt++;
    #3;
    if (reset) begin
      check("reset_vals", {avg_level, day, day_change, sample_ready}, 11'd0);
      exp_q.delete();
      cur_avg = '0;
      cur_day = 1'b0;
    end else begin
      while (exp_q.size() > 0 && exp_q[0].cyc < edge_cnt) begin
        e = exp_q.pop_front();
        tests++;
        fails++;
        $display("FAIL missed_event: expected at edge %0d, now edge %0d", e.cyc, edge_cnt);
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == edge_cnt) begin
        e = exp_q.pop_front();
        cur_avg = e.avg;
        cur_day = e.dy;
        check("event", {avg_level, day, day_change, sample_ready},
              {e.avg, e.dy, e.chg, 1'b1});
        $display("[TB] edge %0d avg=%0d day=%0b chg=%0b (expected avg=%0d day=%0b chg=%0b)",
                 edge_cnt, avg_level, day, day_change, e.avg, e.dy, e.chg);
      end else begin
        check("steady", {avg_level, day, day_change, sample_ready},
              {cur_avg, cur_day, 1'b0, 1'b1});
      end
    end
  end

  // Apply one completed average to the model and queue its expected result.
  task automatic model_avg(int a);
    bit old_day;
    bit new_day;
    old_day = (m_mode == 1);
    if (m_mode == 0) begin
      m_mode = (a >= DT) ? 1 : 2;
      m_persist = 0;
    end else if (m_mode == 1) begin
      if (a < NT) begin
        m_persist++;
        if (m_persist >= HC) begin m_mode = 2; m_persist = 0; end
      end else m_persist = 0;
    end else begin
      if (a >= DT) begin
        m_persist++;
        if (m_persist >= HC) begin m_mode = 1; m_persist = 0; end
      end else m_persist = 0;
    end
    m_avg = a;
    new_day = (m_mode == 1);
    exp_q.push_back('{cyc: edge_cnt + 1, avg: SW'(a), dy: new_day, chg: new_day != old_day});
  endtask

  // One clock cycle of stimulus, called at a falling edge.
  task automatic cyc(bit v, int s);
    int sum;
    bit old_day;
    bit new_day;
    sample_valid = v;
    sample = SW'(s);
`ifdef FORCE_OVERRIDE_EN
    force_en = m_force;
    force_day = m_fday;
`endif
    if (m_force) begin
      old_day = (m_mode == 1);
      m_mode = m_fday ? 1 : 2;
      m_persist = 0;
      win.delete();
      new_day = (m_mode == 1);
      exp_q.push_back('{cyc: edge_cnt + 1, avg: SW'(m_avg), dy: new_day, chg: new_day != old_day});
    end else if (v && model_ready) begin
      win.push_back(s);
      if (win.size() == 4) begin
        sum = 0;
        foreach (win[k]) sum += win[k];
        win.delete();
        model_avg(sum / 4);
      end
    end
    @(negedge clk);
    model_ready = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sample_valid = 1'b0;
    m_mode = 0;
    m_persist = 0;
    m_avg = 0;
    win.delete();
    model_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cyc(1'b1, 255);   // ready is still low on this edge: must be ignored
  endtask

  task automatic send_avg(int v);
    for (int i = 0; i < 4; i++) cyc(1'b1, v);
  endtask

  task automatic send_gap(int s, int max_gap);
    int g;
    g = $urandom_range(max_gap, 0);
    for (int i = 0; i < g; i++) cyc(1'b0, $urandom_range(255, 0));
    cyc(1'b1, s);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    int kind;
    int lo;
    int hi;
    @(negedge clk);
    do_reset();
    cyc(1'b0, 0);

    // 1: first average decides immediately -> day with one pulse
    send_avg(200);
    // 2: 50,50,120,50,50,50 -> 120 clears the count, sixth flips to night
    send_avg(50); send_avg(50); send_avg(120);
    send_avg(50); send_avg(50); send_avg(50);
    // 3: hysteresis band from night, then from day
    for (int i = 0; i < 10; i++) send_avg(120);
    for (int i = 0; i < 3; i++) send_avg(200);
    for (int i = 0; i < 10; i++) send_avg(120);
    // threshold boundaries: 96 is not dark, 95 is; 159 not bright, 160 is
    for (int i = 0; i < 3; i++) send_avg(96);
    for (int i = 0; i < 3; i++) send_avg(95);
    for (int i = 0; i < 3; i++) send_avg(159);
    for (int i = 0; i < 3; i++) send_avg(160);
    // 4: 0,255,255,255 with valid-low gaps -> 191
    send_gap(0, 3); send_gap(255, 3); send_gap(255, 3); send_gap(255, 3);
    // 5: partial window then reset; fresh window takes the INIT path
    cyc(1'b1, 10); cyc(1'b1, 10);
    do_reset();
    send_avg(200);

`ifdef FORCE_OVERRIDE_EN
    // 6: force night from day, with a partial window discarded
    cyc(1'b1, 30); cyc(1'b1, 30);
    m_force = 1'b1; m_fday = 1'b0;
    cyc(1'b1, 200); cyc(1'b0, 0); cyc(1'b1, 200);
    m_force = 1'b0;
    cyc(1'b0, 0);
    for (int i = 0; i < 3; i++) send_avg(200);
    m_force = 1'b1; m_fday = 1'b1;
    cyc(1'b0, 0); cyc(1'b0, 0);
    m_force = 1'b0;
    cyc(1'b0, 0);
`endif

    // Randomised windows drawn from dark / middle / bright bands
    for (int w = 0; w < 150; w++) begin
      kind = $urandom_range(2, 0);
      lo = (kind == 0) ? 0 : (kind == 1) ? 96 : 160;
      hi = (kind == 0) ? 95 : (kind == 1) ? 159 : 255;
      for (int i = 0; i < 4; i++) send_gap($urandom_range(hi, lo), 2);
      if ($urandom_range(39, 0) == 0) begin
        cyc(1'b1, $urandom_range(255, 0));
        do_reset();
      end
    end

    // Drain: allow pending events to be checked, bounded
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) cyc(1'b0, 0);
    cyc(1'b0, 0);
    cyc(1'b0, 0);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expected events left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
